composite_level_mixer: RTL and testbench



---
 rtl/composite_level_mixer_if.sv | 12 +
 rtl/composite_level_mixer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_composite_level_mixer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/composite_level_mixer_if.sv
// Write-only debug register bus shared by the video blocks; each block
// decodes its own page from addr[15:8].
interface debug_bus_if #(
    parameter int DATA_W = 8
);
    logic              write_enable;
    logic [15:0]       addr;
    logic [DATA_W-1:0] wdata;

    modport slave  (input  write_enable, input  addr, input  wdata);
    modport master (output write_enable, output addr, output wdata);
endinterface

// File: rtl/composite_level_mixer.sv
// Composite summing stage: per-standard luma/chroma gains, programmable path delays,
// black-level offset and output clamp. Per-frame clip statistics: COMPOSITE_MIXER_CLIP_STATS_EN.
module composite_level_mixer #(
    parameter int         W           = 8,
    parameter int         NUM_STD     = 4,
    parameter int         DELAY_DEPTH = 32,
    parameter logic [7:0] DBUS_PAGE   = 8'h03
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sync,
    input  logic                       newframe,
    input  logic [$clog2(NUM_STD)-1:0] video_standard,
    input  logic [W-1:0]               luma,
    input  logic [W-1:0]               chroma,
    output logic [W-1:0]               video,
    output logic                       video_clipped,
    output logic [15:0]                clip_count,
    output logic [$clog2(NUM_STD)-1:0] active_std,
    output logic                       mute_active,
    debug_bus_if.slave                 dbus
);
    localparam int SW      = $clog2(NUM_STD);
    localparam int DW      = $clog2(DELAY_DEPTH);
    localparam int NSR     = DELAY_DEPTH - 1;
    localparam int Y_SHIFT = 7;
    localparam int C_SHIFT = 6;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_MUTE    = 2'd2
    } state_t;

    logic [W-1:0]           y_gain_q [NUM_STD];
    logic [W-1:0]           c_gain_q [NUM_STD];
    logic [W-1:0]           black_q;
    logic [DW-1:0]          luma_delay_q;
    logic [DW-1:0]          chroma_delay_q;
    logic                   wr_page_s;

    state_t                 state_q;
    logic [SW-1:0]          active_std_q;
    logic                   mute_q;

    logic [W-1:0]           luma_q;
    logic signed [W-1:0]    chroma_q;
    logic                   sync_q;

    logic [W-1:0]           c_gain_eff_s;
    logic [2*W-1:0]         y_prod_s;
    logic signed [2*W:0]    c_prod_s;
    logic [W:0]             luma_s_d;
    logic signed [W:0]      chroma_s_d;
    logic [W:0]             luma_s_q;
    logic signed [W:0]      chroma_s_q;
    logic                   sync_s2_q;

    logic [W+1:0]           luma_sr_q   [NSR];
    logic signed [W:0]      chroma_sr_q [NSR];
    logic [W+1:0]           luma_tap_s;
    logic signed [W:0]      chroma_tap_s;

    logic signed [W+2:0]    sum_s;
    logic                   neg_s;
    logic                   ovf_s;
    logic                   clip_s;
    logic [W-1:0]           video_d;
    logic [W-1:0]           video_q;
    logic                   clipped_q;

    // Page decode for debug-bus writes.
    always_comb begin
        wr_page_s = dbus.write_enable && (dbus.addr[15:8] == DBUS_PAGE);
    end

    // Register file; a written value is used by the datapath from the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STD; i++) begin
                y_gain_q[i] <= W'(32'd142);
                c_gain_q[i] <= W'(32'd15);
            end
            black_q        <= W'(32'd52);
            luma_delay_q   <= '0;
            chroma_delay_q <= '0;
        end else if (wr_page_s) begin
            for (int i = 0; i < NUM_STD; i++) begin
                if (dbus.addr[7:0] == 8'(i)) begin
                    y_gain_q[i] <= dbus.wdata[W-1:0];
                end
                if (dbus.addr[7:0] == 8'(32'd16 + i)) begin
                    c_gain_q[i] <= dbus.wdata[W-1:0];
                end
            end
            case (dbus.addr[7:0])
                8'h20:   black_q        <= dbus.wdata[W-1:0];
                8'h21:   luma_delay_q   <= dbus.wdata[DW-1:0];
                8'h22:   chroma_delay_q <= dbus.wdata[DW-1:0];
                default: ;
            endcase
        end
    end

    // Gain-bank FSM: a new standard is adopted only on a frame start, then chroma is muted for one frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            active_std_q <= '0;
            mute_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (video_standard != active_std_q) begin
                        state_q <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (video_standard == active_std_q) begin
                        state_q <= ST_RUN;
                    end else if (newframe) begin
                        active_std_q <= video_standard;
                        state_q      <= ST_MUTE;
                        mute_q       <= 1'b1;
                    end
                end
                ST_MUTE: begin
                    if (newframe) begin
                        mute_q  <= 1'b0;
                        state_q <= (video_standard != active_std_q) ? ST_PENDING : ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    mute_q  <= 1'b0;
                end
            endcase
        end
    end

    // S1 input capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_q   <= '0;
            chroma_q <= '0;
            sync_q   <= 1'b0;
        end else begin
            luma_q   <= luma;
            chroma_q <= chroma;
            sync_q   <= sync;
        end
    end

    // S2 gain multiply; chroma is signed, its gain is an unsigned magnitude.
    always_comb begin
        c_gain_eff_s = mute_q ? '0 : c_gain_q[active_std_q];
        y_prod_s     = {{W{1'b0}}, luma_q} * {{W{1'b0}}, y_gain_q[active_std_q]};
        c_prod_s     = (2*W+1)'(chroma_q) * (2*W+1)'($signed({1'b0, c_gain_eff_s}));
        luma_s_d     = (W+1)'(y_prod_s >> Y_SHIFT);
        chroma_s_d   = (W+1)'(c_prod_s >>> C_SHIFT);
    end

    // S2 registers followed by the two delay lines; sync rides in the luma line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luma_s_q   <= '0;
            chroma_s_q <= '0;
            sync_s2_q  <= 1'b0;
            for (int k = 0; k < NSR; k++) begin
                luma_sr_q[k]   <= '0;
                chroma_sr_q[k] <= '0;
            end
        end else begin
            luma_s_q       <= luma_s_d;
            chroma_s_q     <= chroma_s_d;
            sync_s2_q      <= sync_q;
            luma_sr_q[0]   <= {sync_s2_q, luma_s_q};
            chroma_sr_q[0] <= chroma_s_q;
            for (int k = 1; k < NSR; k++) begin
                luma_sr_q[k]   <= luma_sr_q[k-1];
                chroma_sr_q[k] <= chroma_sr_q[k-1];
            end
        end
    end

    // Delay taps: zero bypasses the line, out-of-range settings use the deepest stage.
    always_comb begin
        if (luma_delay_q == '0) begin
            luma_tap_s = {sync_s2_q, luma_s_q};
        end else if (32'(luma_delay_q) > NSR) begin
            luma_tap_s = luma_sr_q[NSR-1];
        end else begin
            luma_tap_s = luma_sr_q[luma_delay_q - DW'(1)];
        end
        if (chroma_delay_q == '0) begin
            chroma_tap_s = chroma_s_q;
        end else if (32'(chroma_delay_q) > NSR) begin
            chroma_tap_s = chroma_sr_q[NSR-1];
        end else begin
            chroma_tap_s = chroma_sr_q[chroma_delay_q - DW'(1)];
        end
    end

    // S3 sum and clamp; sync forces the tip level and suppresses clip detection.
    always_comb begin
        sum_s  = (W+3)'($signed({1'b0, black_q})) + (W+3)'($signed({1'b0, luma_tap_s[W:0]}))
               + (W+3)'(chroma_tap_s);
        neg_s  = sum_s[W+2];
        ovf_s  = !neg_s && (sum_s[W+1:W] != 2'b00);
        clip_s = !luma_tap_s[W+1] && (neg_s || ovf_s);
        if (luma_tap_s[W+1]) begin
            video_d = '0;
        end else if (neg_s) begin
            video_d = '0;
        end else if (ovf_s) begin
            video_d = '1;
        end else begin
            video_d = sum_s[W-1:0];
        end
    end

    // Output register and sticky per-frame clip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_q   <= '0;
            clipped_q <= 1'b0;
        end else begin
            video_q <= video_d;
            if (newframe) begin
                clipped_q <= 1'b0;
            end else if (clip_s) begin
                clipped_q <= 1'b1;
            end
        end
    end

`ifdef COMPOSITE_MIXER_CLIP_STATS_EN
    logic [15:0] run_cnt_q;
    logic [15:0] clip_count_q;
    logic        cnt_inc_s;

    always_comb begin
        cnt_inc_s = clip_s && (run_cnt_q != 16'hFFFF);
    end

    // A clip on the frame-start cycle belongs to the frame that is ending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q    <= 16'd0;
            clip_count_q <= 16'd0;
        end else if (newframe) begin
            clip_count_q <= cnt_inc_s ? run_cnt_q + 16'd1 : run_cnt_q;
            run_cnt_q    <= 16'd0;
        end else if (cnt_inc_s) begin
            run_cnt_q <= run_cnt_q + 16'd1;
        end
    end

    assign clip_count = clip_count_q;
`else
    assign clip_count = 16'd0;
`endif

    assign video         = video_q;
    assign video_clipped = clipped_q;
    assign active_std    = active_std_q;
    assign mute_active   = mute_q;

endmodule

// File: tb/tb_composite_level_mixer.sv
// Randomised bench for composite_level_mixer against a cycle-indexed history model.
`timescale 1ns/1ps
module tb_composite_level_mixer;
    localparam int BASE = 64;
    localparam int HLEN = 4096;
`ifdef COMPOSITE_MIXER_CLIP_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_sync;
    logic        tb_newframe;
    logic [1:0]  tb_vs;
    logic [7:0]  tb_luma;
    logic [7:0]  tb_chroma;
    logic [7:0]  video;
    logic        video_clipped;
    logic [15:0] clip_count;
    logic [1:0]  active_std;
    logic        mute_active;

    debug_bus_if #(.DATA_W(8)) dbus_if ();

    composite_level_mixer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sync           (tb_sync),
        .newframe       (tb_newframe),
        .video_standard (tb_vs),
        .luma           (tb_luma),
        .chroma         (tb_chroma),
        .video          (video),
        .video_clipped  (video_clipped),
        .clip_count     (clip_count),
        .active_std     (active_std),
        .mute_active    (mute_active),
        .dbus           (dbus_if)
    );

    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;
    int e;

    // Per-edge history: inputs sampled at edge n, scaled values produced at edge n.
    int h_il [HLEN];
    int h_ic [HLEN];
    int h_is [HLEN];
    int h_ls [HLEN];
    int h_cs [HLEN];
    int h_sy [HLEN];

    int m_yg [4];
    int m_cg [4];
    int m_black, m_ld, m_cd;
    int m_state;   // 0 run, 1 pending, 2 mute
    int m_std, m_run, m_cnt, m_clipped, m_video;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_vectors++;
        if (obs != exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HLEN; i++) begin
            h_il[i] = 0; h_ic[i] = 0; h_is[i] = 0;
            h_ls[i] = 0; h_cs[i] = 0; h_sy[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            m_yg[i] = 142;
            m_cg[i] = 15;
        end
        m_black = 52; m_ld = 0; m_cd = 0;
        m_state = 0; m_std = 0; m_run = 0; m_cnt = 0; m_clipped = 0; m_video = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_value({tag, "_video"}, int'(video), m_video);
        check_value({tag, "_clipped"}, int'(video_clipped), m_clipped);
        check_value({tag, "_clip_count"}, int'(clip_count), STATS_EN ? m_cnt : 0);
        check_value({tag, "_active_std"}, int'(active_std), m_std);
        check_value({tag, "_mute"}, int'(mute_active), (m_state == 2) ? 1 : 0);
    endtask

    // Advance the model across one clock edge, let the DUT take the same edge, compare.
    task automatic step();
        int cg, cs, lt, ct, st, sum, clip, vs, lo;
        h_ls[e] = (h_il[e-1] * m_yg[m_std]) >> 7;
        cg = (m_state == 2) ? 0 : m_cg[m_std];
        cs = (h_ic[e-1] * cg) >>> 6;
        cs = cs & 511;
        if (cs > 255) cs = cs - 512;
        h_cs[e] = cs;
        h_sy[e] = h_is[e-1];

        lt = h_ls[e-1-m_ld];
        st = h_sy[e-1-m_ld];
        ct = h_cs[e-1-m_cd];
        sum = m_black + lt + ct;
        clip = (st == 0 && (sum < 0 || sum > 255)) ? 1 : 0;
        if (st != 0) m_video = 0;
        else if (sum < 0) m_video = 0;
        else if (sum > 255) m_video = 255;
        else m_video = sum;

        if (tb_newframe) begin
            m_cnt = (m_run + clip > 65535) ? 65535 : m_run + clip;
            m_run = 0;
            m_clipped = 0;
        end else if (clip != 0) begin
            m_clipped = 1;
            if (m_run < 65535) m_run++;
        end

        vs = int'(tb_vs);
        case (m_state)
            0: if (vs != m_std) m_state = 1;
            1: begin
                if (vs == m_std) m_state = 0;
                else if (tb_newframe) begin
                    m_std = vs;
                    m_state = 2;
                end
            end
            2: if (tb_newframe) m_state = (vs != m_std) ? 1 : 0;
            default: m_state = 0;
        endcase

        if (dbus_if.write_enable && dbus_if.addr[15:8] == 8'h03) begin
            lo = int'(dbus_if.addr[7:0]);
            if (lo < 4) m_yg[lo] = int'(dbus_if.wdata);
            else if (lo >= 16 && lo < 20) m_cg[lo-16] = int'(dbus_if.wdata);
            else if (lo == 32) m_black = int'(dbus_if.wdata);
            else if (lo == 33) m_ld = int'(dbus_if.wdata) % 32;
            else if (lo == 34) m_cd = int'(dbus_if.wdata) % 32;
        end

        h_il[e] = int'(tb_luma);
        h_ic[e] = int'($signed(tb_chroma));
        h_is[e] = int'(tb_sync);

        @(posedge clk);
        #1;
        check_outputs("cyc");
        e++;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        dbus_if.write_enable = 1'b1;
        dbus_if.addr = a;
        dbus_if.wdata = d;
        step();
        dbus_if.write_enable = 1'b0;
    endtask

    task automatic pulse_newframe();
        tb_newframe = 1'b1;
        step();
        tb_newframe = 1'b0;
    endtask

    task automatic mid_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_value({tag, "_video"}, int'(video), 0);
        check_value({tag, "_active_std"}, int'(active_std), 0);
        check_value({tag, "_clip_count"}, int'(clip_count), 0);
        check_value({tag, "_clipped"}, int'(video_clipped), 0);
        check_value({tag, "_mute"}, int'(mute_active), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int r;
        logic [7:0] page, lo, dat;
        rst_n = 1'b0;
        tb_sync = 1'b0; tb_newframe = 1'b0; tb_vs = 2'd0;
        tb_luma = 8'd0; tb_chroma = 8'd0;
        dbus_if.write_enable = 1'b0; dbus_if.addr = 16'h0000; dbus_if.wdata = 8'h00;
        e = BASE;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_video", int'(video), 0);
        check_value("rst_clipped", int'(video_clipped), 0);
        check_value("rst_clip_count", int'(clip_count), 0);
        check_value("rst_active_std", int'(active_std), 0);
        check_value("rst_mute", int'(mute_active), 0);
        rst_n = 1'b1;

        // Basic scaling and three-cycle latency.
        bus_write(16'h0300, 8'd128);
        tb_luma = 8'd100;
        step(); step();
        check_value("lat_before", int'(video), 52);
        step();
        check_value("lat_3", int'(video), 152);
        check_value("lat_noclip", int'(video_clipped), 0);

        // Ten clipped samples counted over one frame.
        bus_write(16'h0300, 8'd255);
        pulse_newframe();
        tb_luma = 8'd255;
        repeat (10) step();
        check_value("hi_video", int'(video), 255);
        check_value("hi_clipped", int'(video_clipped), 1);
        tb_luma = 8'd0;
        repeat (4) step();
        pulse_newframe();
        check_value("hi_clip_count", int'(clip_count), STATS_EN ? 10 : 0);
        check_value("hi_clr", int'(video_clipped), 0);

        // Negative clip, then the same stimulus masked by sync.
        bus_write(16'h0310, 8'd64);
        tb_chroma = 8'h80;
        repeat (3) step();
        check_value("neg_video", int'(video), 0);
        check_value("neg_clipped", int'(video_clipped), 1);
        tb_sync = 1'b1;
        repeat (4) step();
        pulse_newframe();
        repeat (4) step();
        check_value("sync_video", int'(video), 0);
        check_value("sync_noclip", int'(video_clipped), 0);
        pulse_newframe();
        check_value("sync_clip_count", int'(clip_count), 0);
        tb_sync = 1'b0;
        tb_chroma = 8'd0;

        // Request a new standard and withdraw it before the frame start.
        tb_luma = 8'd100;
        tb_vs = 2'd1;
        repeat (3) step();
        check_value("wd_active", int'(active_std), 0);
        tb_vs = 2'd0;
        step();
        pulse_newframe();
        check_value("wd_active_nf", int'(active_std), 0);
        check_value("wd_mute_nf", int'(mute_active), 0);

        // Standard switch at frame start with one muted frame.
        tb_chroma = 8'd50;
        tb_vs = 2'd1;
        repeat (5) step();
        check_value("sw_active_pre", int'(active_std), 0);
        pulse_newframe();
        check_value("sw_active", int'(active_std), 1);
        check_value("sw_mute", int'(mute_active), 1);
        repeat (2) step();
        for (int i = 0; i < 20; i++) begin
            step();
            check_value("mute_luma_only", int'(video), 162);
        end
        pulse_newframe();
        check_value("unmute", int'(mute_active), 0);
        repeat (3) step();
        check_value("unmute_video", int'(video), 173);

        // Programmable delays: luma step visible after 3+5 cycles.
        tb_chroma = 8'd0;
        tb_luma = 8'd0;
        repeat (4) step();
        bus_write(16'h0321, 8'd5);
        bus_write(16'h0322, 8'd2);
        repeat (8) step();
        tb_luma = 8'd100;
        repeat (7) step();
        check_value("dly_before", int'(video), 52);
        step();
        check_value("dly_8", int'(video), 162);
        repeat (2) step();
        mid_reset("midrst");

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            tb_luma = 8'($urandom_range(0, 255));
            tb_chroma = 8'($urandom_range(0, 255));
            tb_sync = ($urandom_range(0, 15) == 0);
            tb_newframe = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) tb_vs = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 29);
            page = ($urandom_range(0, 7) == 0) ? 8'h04 : 8'h03;
            dat = 8'($urandom_range(0, 255));
            lo = 8'hFF;
            case (r)
                0: lo = 8'($urandom_range(0, 7));
                1: begin
                    lo = 8'(16 + $urandom_range(0, 7));
                    dat = 8'($urandom_range(0, 127));
                end
                2: lo = 8'h20;
                3: lo = 8'h21;
                4: lo = 8'h22;
                default: lo = 8'hFF;
            endcase
            dbus_if.write_enable = (lo != 8'hFF);
            dbus_if.addr = {page, lo};
            dbus_if.wdata = dat;
            step();
            dbus_if.write_enable = 1'b0;
            if (i == 800) mid_reset("rnd_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
